// File: rtl/dl_arb2_stream_if.sv
// Valid/ready bundle for the two-source stream merge: two producer ports and one consumer port.
// The slave modport is the arbiter's view, and the master modport is the surrounding environment's view.
interface dl_arb2_stream_if #(
  parameter int NUM_BITS = 32
);
  logic [NUM_BITS-1:0] in0_data;
  logic                in0_valid;
  logic                in0_ready;
  logic [NUM_BITS-1:0] in1_data;
  logic                in1_valid;
  logic                in1_ready;
  logic [NUM_BITS-1:0] out_data;
  logic                out_src;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output in0_data, in0_valid, in1_data, in1_valid, out_ready,
    input  in0_ready, in1_ready, out_data, out_src, out_valid
  );

  modport slave (
    input  in0_data, in0_valid, in1_data, in1_valid, out_ready,
    output in0_ready, in1_ready, out_data, out_src, out_valid
  );
endinterface

// File: rtl/dl_arb2_stream.sv
// Two-input round-robin valid/ready merge with a registered output stage.
// It has one cycle of latency and sustains one transfer per cycle.
module dl_arb2_stream #(
  parameter int NUM_BITS = 32
) (
  input logic              clk,
  input logic              rst,
  dl_arb2_stream_if.slave  bus
);

  logic                load;
  logic                any_vld;
  logic                grant;
  logic [NUM_BITS-1:0] data_mux;

  logic [NUM_BITS-1:0] data_p1;
  logic                src_p1;
  logic                vld_p1;
  logic                last_grant;

  assign load    = ~vld_p1 | bus.out_ready;
  assign any_vld = bus.in0_valid | bus.in1_valid;

  // Contention flips the pointer; a lone requester always wins.
  always_comb begin
    grant = 1'b0;
    if (bus.in0_valid && bus.in1_valid)
      grant = ~last_grant;
    else if (bus.in1_valid)
      grant = 1'b1;
  end

  assign data_mux = grant ? bus.in1_data : bus.in0_data;

  // Readies are gated by rst so nothing is accepted while the output stage is being cleared.
  assign bus.in0_ready = ~rst & load & ~grant & bus.in0_valid;
  assign bus.in1_ready = ~rst & load &  grant & bus.in1_valid;

  // Output stage boundary: registered payload, source tag and valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_p1    <= '0;
      src_p1     <= 1'b0;
      vld_p1     <= 1'b0;
      last_grant <= 1'b1;
    end else if (load) begin
      if (any_vld) begin
        data_p1    <= data_mux;
        src_p1     <= grant;
        vld_p1     <= 1'b1;
        last_grant <= grant;
      end else begin
        vld_p1     <= 1'b0;
      end
    end
  end

  assign bus.out_data  = data_p1;
  assign bus.out_src   = src_p1;
  assign bus.out_valid = vld_p1;

endmodule

// File: tb/tb_dl_arb2_stream.sv
// Directed bench for dl_arb2_stream: a linear sequence of steps with hand-computed expectations.
module tb_dl_arb2_stream;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  dl_arb2_stream_if #(.NUM_BITS(32)) bus ();

  dl_arb2_stream #(.NUM_BITS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [31:0] d0,
                       input logic v1, input logic [31:0] d1, input logic ordy);
    bus.in0_valid = v0;
    bus.in0_data  = d0;
    bus.in1_valid = v1;
    bus.in1_data  = d1;
    bus.out_ready = ordy;
  endtask

  task automatic chk_rdy(input string tag, input logic r0, input logic r1);
    #1;
    chk({tag, "_in0_ready"}, {31'd0, bus.in0_ready}, {31'd0, r0});
    chk({tag, "_in1_ready"}, {31'd0, bus.in1_ready}, {31'd0, r1});
  endtask

  task automatic chk_out(input string tag, input logic v, input logic s, input logic [31:0] d);
    chk({tag, "_out_valid"}, {31'd0, bus.out_valid}, {31'd0, v});
    chk({tag, "_out_src"},   {31'd0, bus.out_src},   {31'd0, s});
    chk({tag, "_out_data"},  bus.out_data, d);
  endtask

  logic [31:0] exp_seq [8];
  int          i0;
  int          i1;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    exp_seq = '{32'hA0, 32'hB0, 32'hA1, 32'hB1, 32'hA2, 32'hB2, 32'hA3, 32'hB3};

    // Reset with both sources valid.
    rst = 1'b1;
    drive(1'b1, 32'hC0, 1'b1, 32'hC1, 1'b1);
    #1;
    chk_out("rst", 1'b0, 1'b0, 32'h0);
    chk_rdy("rst", 1'b0, 1'b0);

    @(negedge clk);
    rst = 1'b0;
    chk_rdy("rel", 1'b1, 1'b0);
    tick();
    chk_out("rel", 1'b1, 1'b0, 32'hC0);

    // Only in1 is valid, sending two payloads back to back.
    drive(1'b0, 32'h0, 1'b1, 32'h1234_5678, 1'b1);
    chk_rdy("single0", 1'b0, 1'b1);
    tick();
    chk_out("single0", 1'b1, 1'b1, 32'h1234_5678);
    drive(1'b0, 32'h0, 1'b1, 32'h0BAD_F00D, 1'b1);
    chk_rdy("single1", 1'b0, 1'b1);
    tick();
    chk_out("single1", 1'b1, 1'b1, 32'h0BAD_F00D);

    // Continuous contention (last_grant=1, so in0 goes first).
    i0 = 0;
    i1 = 0;
    for (int k = 0; k < 8; k++) begin
      drive(i0 < 4, 32'hA0 + i0, i1 < 4, 32'hB0 + i1, 1'b1);
      chk_rdy($sformatf("cont%0d", k), (k % 2) == 0, (k % 2) == 1);
      if (bus.in0_valid && bus.in0_ready) i0++;
      if (bus.in1_valid && bus.in1_ready) i1++;
      tick();
      chk_out($sformatf("cont%0d", k), 1'b1, k[0], exp_seq[k]);
    end

    // Backpressure: first load 0x11 from in0, leaving last_grant at 0.
    drive(1'b1, 32'h11, 1'b0, 32'h0, 1'b1);
    tick();
    chk_out("bp_load", 1'b1, 1'b0, 32'h11);
    drive(1'b1, 32'h21, 1'b1, 32'h31, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk_rdy($sformatf("bp_stall%0d", k), 1'b0, 1'b0);
      tick();
      chk_out($sformatf("bp_stall%0d", k), 1'b1, 1'b0, 32'h11);
    end
    bus.out_ready = 1'b1;
    chk_rdy("bp_release", 1'b0, 1'b1);
    tick();
    chk_out("bp_release", 1'b1, 1'b1, 32'h31);

    // Idle drain: a single 0x55 from in0, then no valids.
    drive(1'b1, 32'h55, 1'b0, 32'h0, 1'b1);
    chk_rdy("drain_in", 1'b1, 1'b0);
    tick();
    chk_out("drain_in", 1'b1, 1'b0, 32'h55);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk_rdy("drain_idle", 1'b0, 1'b0);
    tick();
    chk("drain_out_valid", {31'd0, bus.out_valid}, 32'd0);
    drive(1'b1, 32'h66, 1'b1, 32'h77, 1'b1);
    chk_rdy("drain_next", 1'b0, 1'b1);
    tick();
    chk_out("drain_next", 1'b1, 1'b1, 32'h77);

    // Move last_grant to 0, hold the output, then reset asynchronously between edges.
    drive(1'b1, 32'h44, 1'b0, 32'h0, 1'b1);
    tick();
    chk_out("pre_rst", 1'b1, 1'b0, 32'h44);
    drive(1'b1, 32'h88, 1'b1, 32'h99, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_out("async_rst", 1'b0, 1'b0, 32'h0);
    chk_rdy("async_rst", 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    chk_rdy("post_rst", 1'b1, 1'b0);
    tick();
    chk_out("post_rst", 1'b1, 1'b0, 32'h88);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
